// File: rtl/feature_store_writer_pkg.sv
// Shared constants for the feature-map store writer: beat geometry, address
// width and the FSM state encodings used by feature_store_writer.
package feature_store_writer_pkg;

   localparam int STORE_LANES  = 4;   // lane words per memory beat
   localparam int STORE_ADDR_W = 16;  // memory beat-address width
   localparam int STORE_WORD_W = 16;  // bits per lane word

   localparam logic [1:0] SW_IDLE = 2'd0;
   localparam logic [1:0] SW_RUN  = 2'd1;
   localparam logic [1:0] SW_DONE = 2'd2;

endpackage

// File: rtl/feature_store_writer_store_bundle_fifo.sv
// store_bundle_fifo: two-entry bundle FIFO between the output buffer store
// path and the beat serializer. The caller never pushes when count==2; push
// and pop in the same cycle at count 1 leaves the count at 1.
module store_bundle_fifo #(
   parameter int WIDTH = 1792
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] slot [2];
   logic             wr_ptr;
   logic             rd_ptr;

   // Bundle storage; contents are only meaningful while count says so
   always_ff @(posedge clk) begin
      if (push) slot[wr_ptr] <= push_data;
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = slot[rd_ptr];

endmodule

// File: rtl/feature_store_writer.sv
// feature_store_writer: takes saturated 16-bit result bundles from the output
// buffer, queues them in a 2-entry FIFO and writes each one to feature-map
// BRAM as MAC_NUM/LANES beats at consecutive (wrapping) beat addresses.
// Optional build macro STORE_RELU_EN: negative lane words are zeroed at FIFO
// push; timing is the same either way.
module feature_store_writer
   import feature_store_writer_pkg::*;
#(
   parameter int MAC_NUM = 112,
   parameter int WORD_W  = STORE_WORD_W,
   parameter int LANES   = STORE_LANES,
   parameter int ADDR_W  = STORE_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         cfg_base_addr,
   input  logic [15:0]               cfg_bundle_cnt,
   input  logic                      store_valid,
   input  logic [MAC_NUM*WORD_W-1:0] store_data,
   output logic                      store_ready,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [LANES*WORD_W-1:0]   mem_wdata,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                state_dbg
);

   localparam int BEATS    = MAC_NUM / LANES;
   localparam int BEAT_W   = LANES * WORD_W;
   localparam int BUNDLE_W = MAC_NUM * WORD_W;
   localparam int BIDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);

   if ((MAC_NUM % LANES) != 0) begin : g_bad_geometry
      $error("feature_store_writer: MAC_NUM must be a multiple of LANES");
   end

   logic [1:0]          state;
   logic [15:0]         bundle_cnt;   // bundles in the current job
   logic [15:0]         accepted;     // bundles taken from the producer
   logic [15:0]         written;      // bundles fully written to memory
   logic [BIDX_W-1:0]   beat_idx;     // beat of the head bundle on mem_*
   logic [BUNDLE_W-1:0] push_data;
   logic [BUNDLE_W-1:0] fifo_head;
   logic [1:0]          fifo_count;
   logic                push;
   logic                pop;
   logic                beat_xfer;
   logic                last_beat;

   // Handshakes: both ports are strict valid/ready. A transfer happens on a
   // rising edge where valid & ready are both high; valid is never withdrawn
   // and payload never changes while waiting. store_ready and mem_valid are
   // decoded from flops only, so neither depends on the opposite side's input.
   assign store_ready = (state == SW_RUN) && (fifo_count < 2'd2) && (accepted < bundle_cnt);
   assign mem_valid   = (state == SW_RUN) && (fifo_count != 2'd0);
   assign push        = store_valid && store_ready;
   assign beat_xfer   = mem_valid && mem_ready;
   assign last_beat   = (beat_idx == LAST_BEAT);
   assign pop         = beat_xfer && last_beat;

   assign mem_wdata = mem_valid ? fifo_head[beat_idx * BEAT_W +: BEAT_W] : '0;
   assign busy      = (state == SW_RUN) || (state == SW_DONE);
   assign done      = (state == SW_DONE);
   assign state_dbg = state;

`ifdef STORE_RELU_EN
   // Zero every negative lane word as the bundle enters the FIFO
   always_comb begin
      push_data = store_data;
      for (int j = 0; j < MAC_NUM; j++) begin
         if (store_data[j*WORD_W + WORD_W - 1]) push_data[j*WORD_W +: WORD_W] = '0;
      end
   end
`else
   assign push_data = store_data;
`endif

   store_bundle_fifo #(
      .WIDTH (BUNDLE_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   // Job FSM with address, beat and bundle counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SW_IDLE;
         bundle_cnt <= '0;
         accepted   <= '0;
         written    <= '0;
         beat_idx   <= '0;
         mem_addr   <= '0;
      end else begin
         case (state)
            SW_IDLE: begin
               if (start) begin
                  bundle_cnt <= cfg_bundle_cnt;
                  mem_addr   <= cfg_base_addr;
                  accepted   <= '0;
                  written    <= '0;
                  beat_idx   <= '0;
                  state      <= (cfg_bundle_cnt == 16'd0) ? SW_DONE : SW_RUN;
               end
            end
            SW_RUN: begin
               if (push) accepted <= accepted + 16'd1;
               if (beat_xfer) begin
                  mem_addr <= mem_addr + ADDR_W'(1);
                  if (last_beat) begin
                     beat_idx <= '0;
                     written  <= written + 16'd1;
                     if ((written + 16'd1) == bundle_cnt) state <= SW_DONE;
                  end else begin
                     beat_idx <= beat_idx + BIDX_W'(1);
                  end
               end
            end
            SW_DONE: state <= SW_IDLE;
            default: state <= SW_IDLE;
         endcase
      end
   end

endmodule
